// File: rtl/instr_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: fetched-entry record and
// the fetch FSM state encoding.
package instr_fetch_queue_pkg;

    localparam int unsigned RV32I_XLEN = 32;

    typedef logic [RV32I_XLEN-1:0] rv32i_word;

    typedef struct packed {
        rv32i_word pc;
        rv32i_word instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Memory-read handshake, redirect and dispatch-side signals of the fetch queue.
// master = the queue itself, slave = memory/dispatch environment.
interface instr_fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             instr_read;
    logic [XLEN-1:0]  instr_mem_address;
    logic             instr_mem_resp;
    logic [XLEN-1:0]  instr_mem_rdata;
    logic             flush;
    logic [XLEN-1:0]  flush_pc;
    logic             deq_ready;
    logic             deq_valid;
    logic [XLEN-1:0]  deq_instr;
    logic [XLEN-1:0]  deq_pc;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;

    modport master (
        output instr_read, instr_mem_address, deq_valid, deq_instr, deq_pc,
               count, full, empty,
        input  instr_mem_resp, instr_mem_rdata, flush, flush_pc, deq_ready
    );

    modport slave (
        input  instr_read, instr_mem_address, deq_valid, deq_instr, deq_pc,
               count, full, empty,
        output instr_mem_resp, instr_mem_rdata, flush, flush_pc, deq_ready
    );

endinterface

// File: rtl/instr_fetch_queue_circ_fifo.sv
// Circular FIFO with head/tail/count bookkeeping and a synchronous clear that
// dominates enqueue and dequeue. DEPTH must be a power of two.
module circ_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = logic [63:0]
) (
    input  logic                         clk,
    input  logic                         clr_i,
    input  logic                         enq_i,
    input  entry_t                       enq_data_i,
    input  logic                         deq_i,
    output entry_t                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t           mem_q [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_enq_s;
    logic             do_deq_s;

    assign full_o   = (count_q == CNT_W'(DEPTH));
    assign empty_o  = (count_q == {CNT_W{1'b0}});
    assign do_enq_s = enq_i & ~full_o;
    assign do_deq_s = deq_i & ~empty_o;
    assign head_o   = mem_q[head_q];
    assign count_o  = count_q;

    // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clr_i) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (do_enq_s) begin
                tail_d = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
            if (do_deq_s) begin
                head_d = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            case ({do_enq_s, do_deq_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers, cleared synchronously.
    always_ff @(posedge clk) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

    // Entry storage; contents beyond count are don't-care so no reset is needed.
    always_ff @(posedge clk) begin
        if (!clr_i && do_enq_s) begin
            mem_q[tail_q] <= enq_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: single-outstanding memory read engine feeding a
// first-word-fall-through FIFO, with branch redirect and stale-response drop.
module instr_fetch_queue
    import instr_fetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH    = 8,
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h6000_0000
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_queue_if.master bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  stale_pc_q, stale_pc_d;

    logic             read_s;
    logic [XLEN-1:0]  addr_s;
    logic             enq_s;
    logic             deq_s;
    logic             clr_s;
    fetch_entry_t     enq_entry_s;
    fetch_entry_t     head_entry_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             full_s;
    logic             empty_s;

    // Status is forced to the idle view while reset is held.
    assign full_s      = fifo_full_s & ~rst;
    assign empty_s     = fifo_empty_s | rst;
    assign deq_s       = ~empty_s & bus.deq_ready;
    assign clr_s       = rst | bus.flush;
    assign enq_entry_s = fetch_entry_t'{pc: pc_q, instr: bus.instr_mem_rdata};

    // Fetch FSM: request generation, PC advance, and redirect handling.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        stale_pc_d = stale_pc_q;
        read_s     = 1'b0;
        addr_s     = pc_q;
        enq_s      = 1'b0;
        case (state_q)
            FETCH: begin
                read_s = ~full_s & ~rst;
                addr_s = pc_q;
                if (bus.flush) begin
                    pc_d = bus.flush_pc;
                    // Memory cannot abort, so an in-flight read must be drained.
                    if (read_s && !bus.instr_mem_resp) begin
                        stale_pc_d = pc_q;
                        state_d    = DROP;
                    end else begin
                        state_d    = FETCH;
                    end
                end else if (read_s && bus.instr_mem_resp) begin
                    enq_s = 1'b1;
                    pc_d  = pc_q + XLEN'(4);
                end else begin
                    pc_d  = pc_q;
                end
            end
            DROP: begin
                read_s = ~rst;
                addr_s = stale_pc_q;
                if (bus.flush) begin
                    pc_d = bus.flush_pc;
                end else begin
                    pc_d = pc_q;
                end
                if (bus.instr_mem_resp) begin
                    state_d = FETCH;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = FETCH;
                read_s  = 1'b0;
                addr_s  = pc_q;
            end
        endcase
    end

    // FSM state and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            stale_pc_q <= {XLEN{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            stale_pc_q <= stale_pc_d;
        end
    end

    circ_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk        (clk),
        .clr_i      (clr_s),
        .enq_i      (enq_s),
        .enq_data_i (enq_entry_s),
        .deq_i      (deq_s),
        .head_o     (head_entry_s),
        .count_o    (fifo_count_s),
        .full_o     (fifo_full_s),
        .empty_o    (fifo_empty_s)
    );

    assign bus.instr_read        = read_s;
    assign bus.instr_mem_address = addr_s;
    assign bus.deq_valid         = ~empty_s;
    assign bus.deq_instr         = head_entry_s.instr;
    assign bus.deq_pc            = head_entry_s.pc;
    assign bus.count             = fifo_count_s;
    assign bus.full              = full_s;
    assign bus.empty             = empty_s;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: constant vector table, directed corner sequences
// and a randomized run checked against a queue-based reference model.
module tb_instr_fetch_queue;
    import instr_fetch_queue_pkg::*;

    localparam int          DEPTH  = 8;
    localparam logic [31:0] RST_PC = 32'h6000_0000;

    logic clk = 1'b0;
    logic rst;

    instr_fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

    instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: queue of entries plus a pending-discard marker
    fetch_entry_t m_q[$];
    logic [31:0]  m_pc;
    logic [31:0]  m_stale;
    bit           m_discard;

    bit          e_read, e_valid, e_full, e_empty;
    logic [31:0] e_addr;
    int          e_count;
    bit          c_rst, c_flush, c_dr, c_resp;
    logic [31:0] c_fpc, c_rdata;

    // memory responder
    bit          mem_busy, mem_force, rand_lat;
    int          mem_wait, mem_lat, fixed_lat;
    logic [31:0] mem_addr;
    logic [31:0] resp_log[$];

    bit          seq_on, seq_have, seen_dead;
    logic [31:0] seq_last;

    typedef struct {
        bit          rst;
        bit          dr;
        bit          e_read;
        logic [31:0] e_addr;
        int          e_count;
        bit          e_full;
        bit          e_valid;
        logic [31:0] e_pc;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic drive(input bit r, input bit fl, input logic [31:0] fpc, input bit dr);
        e_read  = !r && (m_discard || m_q.size() < DEPTH);
        e_addr  = m_discard ? m_stale : m_pc;
        e_valid = !r && m_q.size() > 0;
        e_count = m_q.size();
        e_full  = !r && m_q.size() == DEPTH;
        e_empty = r || m_q.size() == 0;
        rst = r; bus.flush = fl; bus.flush_pc = fpc; bus.deq_ready = dr;
        c_rst = r; c_flush = fl; c_fpc = fpc; c_dr = dr;
        #1;
        c_resp = 1'b0;
        if (!r && bus.instr_read) begin
            if (mem_busy) begin
                chk("addr_stable", bus.instr_mem_address, mem_addr);
            end else begin
                mem_busy = 1'b1;
                mem_addr = bus.instr_mem_address;
                mem_wait = 0;
                mem_lat  = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
            end
            c_resp = (mem_wait >= mem_lat);
        end else if (!r && mem_busy) begin
            chk("read_held", 32'(bus.instr_read), 32'd1);
        end
        c_rdata = c_resp ? (mem_force ? 32'hDEAD_BEEF : mem_data(mem_addr)) : $urandom;
        bus.instr_mem_resp  = c_resp;
        bus.instr_mem_rdata = c_rdata;
        #1;
        if (bus.deq_valid && bus.deq_instr == 32'hDEAD_BEEF) seen_dead = 1'b1;
        if (seq_on && !r && !fl && bus.deq_valid && dr) begin
            if (seq_have) chk("seq_pc", bus.deq_pc, seq_last + 32'd4);
            seq_last = bus.deq_pc;
            seq_have = 1'b1;
        end
    endtask

    task automatic check_model();
        chk("instr_read", 32'(bus.instr_read), 32'(e_read));
        if (!c_rst) begin
            chk("address", bus.instr_mem_address, e_addr);
            chk("count", 32'(bus.count), 32'(e_count));
        end
        chk("deq_valid", 32'(bus.deq_valid), 32'(e_valid));
        chk("full", 32'(bus.full), 32'(e_full));
        chk("empty", 32'(bus.empty), 32'(e_empty));
        if (e_valid) begin
            chk("deq_pc", bus.deq_pc, m_q[0].pc);
            chk("deq_instr", bus.deq_instr, m_q[0].instr);
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        if (c_rst) begin
            m_q.delete();
            m_pc      = RST_PC;
            m_discard = 1'b0;
        end else if (m_discard) begin
            if (c_flush) m_pc = c_fpc;
            if (c_resp)  m_discard = 1'b0;
        end else if (c_flush) begin
            m_q.delete();
            if (e_read && !c_resp) begin
                m_discard = 1'b1;
                m_stale   = m_pc;
            end
            m_pc = c_fpc;
        end else begin
            if (e_valid && c_dr) void'(m_q.pop_front());
            if (e_read && c_resp) begin
                m_q.push_back(fetch_entry_t'{pc: m_pc, instr: c_rdata});
                m_pc = m_pc + 32'd4;
            end
        end
        if (c_rst) begin
            mem_busy  = 1'b0;
            mem_force = 1'b0;
        end else if (c_resp) begin
            mem_busy  = 1'b0;
            mem_force = 1'b0;
            resp_log.push_back(mem_addr);
        end else if (mem_busy) begin
            mem_wait++;
        end
        @(negedge clk);
    endtask

    task automatic cyc(input bit r, input bit fl, input logic [31:0] fpc, input bit dr);
        drive(r, fl, fpc, dr);
        check_model();
        finish_cycle();
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0; bus.flush_pc = 32'd0; bus.deq_ready = 1'b0;
        bus.instr_mem_resp = 1'b0; bus.instr_mem_rdata = 32'd0;
        m_pc = RST_PC; m_stale = 32'd0; m_discard = 1'b0;
        mem_busy = 1'b0; mem_force = 1'b0; rand_lat = 1'b0; fixed_lat = 0;
        seq_on = 1'b0; seq_have = 1'b0; seen_dead = 1'b0; seq_last = 32'd0;

        // reset, fill to full with single-cycle memory, then one dequeue
        tbl[0] = '{1'b1, 1'b0, 1'b0, RST_PC, 0, 1'b0, 1'b0, RST_PC};
        for (int k = 1; k <= 8; k++)
            tbl[k] = '{1'b0, 1'b0, 1'b1, RST_PC + 32'(4 * (k - 1)), k - 1, 1'b0, (k > 1), RST_PC};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, RST_PC + 32'h20, 8, 1'b1, 1'b1, RST_PC};
        tbl[10] = '{1'b0, 1'b1, 1'b0, RST_PC + 32'h20, 8, 1'b1, 1'b1, RST_PC};
        tbl[11] = '{1'b0, 1'b0, 1'b1, RST_PC + 32'h20, 7, 1'b0, 1'b1, RST_PC + 32'd4};

        drive(1'b1, 1'b0, 32'd0, 1'b0);
        finish_cycle();

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].rst, 1'b0, 32'd0, tbl[i].dr);
            chk($sformatf("tbl%0d_read", i), 32'(bus.instr_read), 32'(tbl[i].e_read));
            chk($sformatf("tbl%0d_valid", i), 32'(bus.deq_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].e_full));
            chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(!tbl[i].e_valid));
            if (!tbl[i].rst) begin
                chk($sformatf("tbl%0d_addr", i), bus.instr_mem_address, tbl[i].e_addr);
                chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].e_count));
            end
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), bus.deq_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_instr", i), bus.deq_instr, mem_data(tbl[i].e_pc));
            end
            finish_cycle();
        end

        // full queue streaming across pointer wrap
        seq_on = 1'b1; seq_have = 1'b1; seq_last = RST_PC;
        for (int i = 0; i < 30; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        seq_on = 1'b0;

        // fixed 3-cycle memory latency
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        resp_log.delete();
        fixed_lat = 3;
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("lat3_resp_count", 32'(resp_log.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++)
            if (i < resp_log.size()) chk("lat3_addr", resp_log[i], RST_PC + 32'(4 * i));

        // flush with a request in flight; stale data is DEADBEEF
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        resp_log.delete();
        seen_dead = 1'b0;
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        mem_force = 1'b1;
        cyc(1'b0, 1'b1, 32'h6000_1000, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("flush_empty", 32'(bus.empty), 32'd1);
        chk("drop_addr", bus.instr_mem_address, RST_PC);
        check_model();
        finish_cycle();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 32'd0, 1'b1);
        chk("flush_resp_count", 32'(resp_log.size() >= 2), 32'd1);
        if (resp_log.size() >= 2) chk("flush_next_addr", resp_log[1], 32'h6000_1000);
        chk("no_deadbeef", 32'(seen_dead), 32'd0);

        // flush coincident with response, then a second flush while draining
        cyc(1'b1, 1'b0, 32'd0, 1'b0);
        resp_log.delete();
        fixed_lat = 0;
        cyc(1'b0, 1'b1, 32'h6000_2000, 1'b1);
        fixed_lat = 3;
        cyc(1'b0, 1'b1, 32'h6000_3000, 1'b1);
        cyc(1'b0, 1'b1, 32'h6000_4000, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 1'b0, 32'd0, 1'b1);
        fixed_lat = 0;
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        chk("resume_read", 32'(bus.instr_read), 32'd1);
        chk("resume_addr", bus.instr_mem_address, 32'h6000_4000);
        check_model();
        finish_cycle();
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'd0, 1'($urandom_range(0, 1)));
        chk("dflush_resp_count", 32'(resp_log.size() >= 3), 32'd1);
        if (resp_log.size() >= 3) begin
            chk("dflush_log0", resp_log[0], RST_PC);
            chk("dflush_log1", resp_log[1], 32'h6000_2000);
            chk("dflush_log2", resp_log[2], 32'h6000_4000);
        end

        // reset with 4 queued entries and a read in flight, then reset while draining
        for (int v = 0; v < 2; v++) begin
            cyc(1'b1, 1'b0, 32'd0, 1'b0);
            fixed_lat = 0;
            for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'd0, 1'b0);
            fixed_lat = 3;
            drive(1'b0, 1'b0, 32'd0, 1'b0);
            chk("rst_pre_count", 32'(bus.count), 32'd4);
            check_model();
            finish_cycle();
            if (v == 1) cyc(1'b0, 1'b1, 32'h6000_5000, 1'b0);
            cyc(1'b1, 1'b0, 32'd0, 1'b0);
            drive(1'b0, 1'b0, 32'd0, 1'b0);
            chk("rst_count", 32'(bus.count), 32'd0);
            chk("rst_valid", 32'(bus.deq_valid), 32'd0);
            chk("rst_read", 32'(bus.instr_read), 32'd1);
            chk("rst_addr", bus.instr_mem_address, RST_PC);
            check_model();
            finish_cycle();
        end

        // randomized traffic against the model
        rand_lat = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            bit          r, fl, dr;
            logic [31:0] fpc;
            r   = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 29) == 0);
            dr  = 1'($urandom_range(0, 1));
            fpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3)))
                                              : ($urandom & 32'hFFFF_FFFC);
            cyc(r, fl, fpc, dr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction fetch queue sitting between instruction memory and the instruction-queue/dispatch stage of the Tomasulo core. It drives one outstanding instruction-memory read at a time, buffers up to DEPTH fetched instructions with their PCs in a circular FIFO, and presents them first-word-fall-through to dispatch. It adds a branch-redirect flush, which must also discard an in-flight memory response, and it exposes occupancy status.

## Interface
- DEPTH, 8, FIFO entries; power of two, at least 2.
- XLEN, 32, instruction and address width.
- RESET_PC, 32'h6000_0000, PC of the first fetch after reset.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset; one clock, sampled on the rising edge of clk.
- instr_read  out  1  memory read request; held high until instr_mem_resp.
- instr_mem_address  out  XLEN  fetch address; stable while instr_read is high.
- instr_mem_resp  in  1  read complete; data valid in the same cycle.
- instr_mem_rdata  in  XLEN  fetched instruction.
- flush  in  1  redirect pulse from the ROB or branch unit.
- flush_pc  in  XLEN  new fetch PC, sampled when flush=1.
- deq_ready  in  1  dispatch accepts the head entry this cycle.
- deq_valid  out  1  head entry valid; equals !empty.
- deq_instr  out  XLEN  head instruction.
- deq_pc  out  XLEN  head PC.
- count  out  $clog2(DEPTH+1)  occupied entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.

## Operation
- The FSM has two states:
  - FETCH: instr_read = !full; instr_mem_address = pc.
  - DROP: instr_read = 1; instr_mem_address = stale_pc.
- FETCH with instr_read && instr_mem_resp:
  - enqueue {pc, instr_mem_rdata} at tail;
  - pc <= pc+4; tail wraps modulo DEPTH.
- Space is guaranteed at response time:
  - a request starts only when !full;
  - only one request is outstanding;
  - count cannot grow while the request waits.
- Dequeue fires on deq_valid && deq_ready: head advances modulo DEPTH.
- Simultaneous enqueue and dequeue leave count unchanged. Both are legal when full: no enqueue can occur then. Both are legal when empty: the new entry appears next cycle, with no bypass.
- Flush has priority over enqueue and dequeue:
  - head, tail and count go to 0; pc <= flush_pc.
  - If instr_read=1 and instr_mem_resp=0 (request in flight): stale_pc <= current address; next state DROP. Memory cannot abort a request.
  - If instr_mem_resp=1 in the flush cycle: data is discarded; stay in FETCH.
- DROP: on instr_mem_resp, data is discarded and the state goes to FETCH.
- A flush received while in DROP updates pc only; the state stays DROP.
- PC arithmetic is modulo 2^XLEN. Wrap past all-ones is not an error.

## Timing
- Reset values: state FETCH; pc = RESET_PC; head = tail = count = 0.
- Outputs during the reset cycle: instr_read=0, deq_valid=0, empty=1, full=0. deq_instr and deq_pc are don't-care.
- Cycle after reset deasserts: instr_read=1 with address RESET_PC.
- A response in cycle t:
  - deq_valid=1 and count increment are visible in t+1;
  - the next request (pc+4) is asserted in t+1.
- Single-cycle memory therefore sustains 1 instruction per cycle.
- The dequeue/count effect is visible in the cycle after the deq_ready handshake.
- Flush in cycle t: empty=1 in t+1. The first fetch at flush_pc is in t+1 (FETCH) or in the cycle after the stale response (DROP).
- rst mid-operation (including in DROP) returns everything to reset values. The in-flight response is ignored because state is FETCH with count reset. Memory is required to be reset by the same rst.

## Structure
- tomasula_types gains fetch_entry_t {rv32i_word pc; rv32i_word instr;}.
- tomasula_types gains the FSM enum fetch_state_e {FETCH, DROP}.
- One sub-module: circ_fifo, parametrised on DEPTH and entry type.
  - Holds head, tail, count, storage and full/empty, with a synchronous clear input driven by flush|rst.
  - instr_fetch_queue adds the FSM, the PC registers and the memory handshake.

## Test plan
- Reset, then memory responding with a fixed 3-cycle latency:
  - addresses 6000_0000, 6000_0004, 6000_0008 issued in order, one at a time;
  - each entry's deq_pc matches its address and deq_instr matches the data.
- deq_ready=0 with single-cycle memory:
  - count climbs to 8 and full=1;
  - instr_read drops while full and address 6000_0020 is held;
  - one dequeue re-asserts instr_read in the following cycle.
- Full queue, deq_ready=1 with a response every cycle: count stays at DEPTH-1/DEPTH boundary with no lost or duplicated PCs across head/tail wrap (check at least 20 entries).
- Flush to 6000_1000 while a request is in flight, memory responding 2 cycles later with 0xDEADBEEF:
  - the queue empties and 0xDEADBEEF never reaches deq_instr;
  - the next instr_read carries 6000_1000.
- Flush coincident with instr_mem_resp, plus a second flush issued while in DROP: the data is discarded, and fetch resumes at the last flush_pc.
- rst asserted while in DROP with 4 queued entries:
  - next cycle: count=0, deq_valid=0;
  - the following fetch address is 6000_0000.
